// File: rtl/theta_sin_iter.sv
// Iterative sin(theta) from cos(theta): computes +/- sqrt(1 - x^2) in signed Q-format
// using a truncated square followed by a bit-serial restoring square root.
module theta_sin_iter #(
  parameter int Q     = 32,
  parameter int N     = 34,
  parameter int TAG_W = 4
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [N-1:0]     thetaCos_i,
  input  logic                    sign_i,
  input  logic        [TAG_W-1:0] tag_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [N-1:0]     thetaSin_o,
  output logic                    clamp_o,
  output logic        [TAG_W-1:0] tag_o
);

  localparam int CNT_W = $clog2(Q + 1);
  localparam int SQ_W  = Q + 2;
  localparam int RAD_W = 2 * Q + 2;
  localparam int REM_W = Q + 3;
  localparam logic [SQ_W-1:0] ONE_SQ = {2'b01, {Q{1'b0}}};

  typedef enum logic [2:0] {IDLE, SQUARE, SUB, ROOT, DONE} state_t;

  state_t                  state;
  logic signed [N-1:0]     xR;
  logic                    sgnR;
  logic        [TAG_W-1:0] tagR;
  logic                    clampR;
  logic        [SQ_W-1:0]  sqR;
  logic        [RAD_W-1:0] radR;
  logic        [REM_W-1:0] remR;
  logic        [Q:0]       rootR;
  logic        [CNT_W-1:0] cntR;

  logic signed [2*N-1:0]   xExt;
  logic signed [2*N-1:0]   prod;
  logic        [REM_W+1:0] remShift;
  logic        [REM_W+1:0] trial;
  logic        [REM_W-1:0] remNext;
  logic        [Q:0]       rootNext;
  logic        [Q:0]       diff;
  logic                    sqGe;
  logic                    sqGt;
  logic                    inXfer;

  // Truncated x*x >> Q, saturated to the register width; any saturated value is > 1.0.
  function automatic logic [SQ_W-1:0] satSq(input logic signed [2*N-1:0] p);
    logic [2*N-1:0] s;
    s = $unsigned(p) >> Q;
    if (|s[2*N-1:SQ_W]) satSq = '1;
    else                satSq = s[SQ_W-1:0];
  endfunction

  function automatic logic signed [N-1:0] applySign(input logic [Q:0] r, input logic neg);
    logic signed [N-1:0] v;
    v = $signed({{(N-Q-1){1'b0}}, r});
    applySign = neg ? -v : v;
  endfunction

  assign in_ready_o = (state == IDLE) || ((state == DONE) && out_ready_i);
  assign inXfer     = in_valid_i && in_ready_o;

  always_comb begin
    xExt     = {{N{xR[N-1]}}, xR};
    prod     = xExt * xExt;
    sqGe     = sqR >= ONE_SQ;
    sqGt     = sqR > ONE_SQ;
    diff     = ONE_SQ[Q:0] - sqR[Q:0];
    remShift = {remR, radR[RAD_W-1 -: 2]};
    trial    = {{(REM_W-Q-1){1'b0}}, rootR, 2'b01};
    remNext  = remShift[REM_W-1:0];
    rootNext = {rootR[Q-1:0], 1'b0};
    if (remShift >= trial) begin
      remNext  = REM_W'(remShift - trial);
      rootNext = {rootR[Q-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state       <= IDLE;
      xR          <= '0;
      sgnR        <= 1'b0;
      tagR        <= '0;
      clampR      <= 1'b0;
      sqR         <= '0;
      radR        <= '0;
      remR        <= '0;
      rootR       <= '0;
      cntR        <= '0;
      out_valid_o <= 1'b0;
      thetaSin_o  <= '0;
      clamp_o     <= 1'b0;
      tag_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inXfer) begin
            xR    <= thetaCos_i;
            sgnR  <= sign_i;
            tagR  <= tag_i;
            state <= SQUARE;
          end
        end
        // square stage
        SQUARE: begin
          sqR   <= satSq(prod);
          state <= SUB;
        end
        // 1 - x^2 stage; the radicand is d scaled by 2^Q
        SUB: begin
          clampR <= sqGt;
          radR   <= {1'b0, (sqGe ? {(Q+1){1'b0}} : diff), {Q{1'b0}}};
          remR   <= '0;
          rootR  <= '0;
          cntR   <= CNT_W'(Q);
          state  <= ROOT;
        end
        // one root bit per cycle, MSB first
        ROOT: begin
          remR  <= remNext;
          rootR <= rootNext;
          radR  <= radR << 2;
          if (cntR == '0) begin
            thetaSin_o  <= applySign(rootNext, sgnR);
            clamp_o     <= clampR;
            tag_o       <= tagR;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else begin
            cntR <= cntR - CNT_W'(1);
          end
        end
        // hold the result until the consumer takes it
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            if (in_valid_i) begin
              xR    <= thetaCos_i;
              sgnR  <= sign_i;
              tagR  <= tag_i;
              state <= SQUARE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
